// File: rtl/clknrst_rst_seq.sv
// rtl/clknrst_rst_seq.sv - sequenced reset with soft-reset handshake and post-reset cycle counter
// Optional feature macro: CLKNRST_CYCLE_CNT_EN (builds the cycle_cnt_o counter; otherwise tied to 0)
module clknrst_rst_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             soft_rst_req_i,
   output logic             soft_rst_ack_o,
   output logic             rst_n_o,
   output logic             rst_o,
   output logic             rst_done_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);

   // The final synchronizer stage is the SYNC->HOLD state transition itself, so only
   // SYNC_STAGES-1 explicit shift flops are needed to release on the SYNC_STAGES-th edge.
   localparam int            SL        = SYNC_STAGES - 1;
   localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      RST,
      SYNC,
      HOLD,
      RUN,
      SOFT
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [SL-1:0]   chain;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_nxt;
   logic            armed;
   logic            armed_nxt;
   logic            rst_n_nxt;
   logic            ack_nxt;
   logic            done_nxt;

   // State, synchronizer chain and all registered outputs; async assert, clocked release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RST;
         chain          <= '0;
         hold_cnt       <= '0;
         armed          <= 1'b1;
         rst_n_o        <= 1'b0;
         rst_o          <= 1'b1;
         rst_done_o     <= 1'b0;
         soft_rst_ack_o <= 1'b0;
      end else begin
         state          <= state_nxt;
         chain          <= SL'({chain, 1'b1});
         hold_cnt       <= hold_nxt;
         armed          <= armed_nxt;
         rst_n_o        <= rst_n_nxt;
         rst_o          <= ~rst_n_nxt;
         rst_done_o     <= done_nxt;
         soft_rst_ack_o <= ack_nxt;
      end
   end

   // Next-state and next-output decode for the reset sequencer.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      armed_nxt = armed;
      rst_n_nxt = 1'b0;
      ack_nxt   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         RST, SYNC: begin
            state_nxt = SYNC;
            if (chain[SL-1]) begin
               state_nxt = HOLD;
               hold_nxt  = '0;
            end
         end
         HOLD, SOFT: begin
            hold_nxt = hold_cnt + HW'(1);
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = RUN;
               rst_n_nxt = 1'b1;
               done_nxt  = 1'b1;
               ack_nxt   = (state == SOFT);
            end
         end
         RUN: begin
            rst_n_nxt = 1'b1;
            if (soft_rst_req_i && armed) begin
               state_nxt = SOFT;
               hold_nxt  = '0;
               rst_n_nxt = 1'b0;
               armed_nxt = 1'b0;
            end else if (!soft_rst_req_i) begin
               // A request must be seen low once before another one is honoured.
               armed_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = RST;
         end
      endcase
   end

`ifdef CLKNRST_CYCLE_CNT_EN
   logic [CNT_W-1:0] cnt;

   // Saturating count of cycles since release; zero in the release cycle and while held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!rst_n_o || !rst_n_nxt) begin
         cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign cycle_cnt_o = cnt;
`else
   assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clknrst_rst_seq.sv
// tb/tb_clknrst_rst_seq.sv - scoreboard bench for clknrst_rst_seq (default and small-parameter instances)
module tb_clknrst_rst_seq;

   localparam int S_A = 2;
   localparam int H_A = 8;
   localparam int W_A = 32;
   localparam int S_B = 3;
   localparam int H_B = 1;
   localparam int W_B = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           req = 1'b0;

   logic           ack_a, rstn_a, rst_a, done_a;
   logic [W_A-1:0] cnt_a;
   logic           ack_b, rstn_b, rst_b, done_b;
   logic [W_B-1:0] cnt_b;

   int n_chk = 0;
   int n_fail = 0;

   clknrst_rst_seq #(.SYNC_STAGES(S_A), .HOLD_CYCLES(H_A), .CNT_W(W_A)) dut_a (
      .clk            (clk),
      .reset_n        (reset_n),
      .soft_rst_req_i (req),
      .soft_rst_ack_o (ack_a),
      .rst_n_o        (rstn_a),
      .rst_o          (rst_a),
      .rst_done_o     (done_a),
      .cycle_cnt_o    (cnt_a)
   );

   clknrst_rst_seq #(.SYNC_STAGES(S_B), .HOLD_CYCLES(H_B), .CNT_W(W_B)) dut_b (
      .clk            (clk),
      .reset_n        (reset_n),
      .soft_rst_req_i (req),
      .soft_rst_ack_o (ack_b),
      .rst_n_o        (rstn_b),
      .rst_o          (rst_b),
      .rst_done_o     (done_b),
      .cycle_cnt_o    (cnt_b)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   typedef struct {
      bit              rst_n;
      bit              done;
      bit              ack;
      longint unsigned cnt;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a;
   exp_t e_b;

   // Reference model: per instance, edges remaining until release, running flag, arm flag.
   int              m_left [2];
   bit              m_run  [2];
   bit              m_armed[2];
   bit              m_soft [2];
   bit              m_done [2];
   bit              m_ack  [2];
   longint unsigned m_cnt  [2];

   function automatic int p_s(input int i);
      return (i == 0) ? S_A : S_B;
   endfunction

   function automatic int p_h(input int i);
      return (i == 0) ? H_A : H_B;
   endfunction

   function automatic longint unsigned p_max(input int i);
      longint unsigned one = 1;
      return (i == 0) ? ((one << W_A) - 1) : ((one << W_B) - 1);
   endfunction

   task automatic model_reset(input int i);
      m_run[i]   = 1'b0;
      m_left[i]  = p_s(i) + p_h(i);
      m_armed[i] = 1'b1;
      m_soft[i]  = 1'b0;
      m_done[i]  = 1'b0;
      m_ack[i]   = 1'b0;
      m_cnt[i]   = 0;
   endtask

   task automatic model_edge(input int i, input bit rn, input bit rq);
      if (!rn) begin
         model_reset(i);
         return;
      end
      m_done[i] = 1'b0;
      m_ack[i]  = 1'b0;
      if (!m_run[i]) begin
         m_left[i] = m_left[i] - 1;
         if (m_left[i] == 0) begin
            m_run[i]  = 1'b1;
            m_done[i] = 1'b1;
            m_ack[i]  = m_soft[i];
            m_soft[i] = 1'b0;
            m_cnt[i]  = 0;
         end
      end else if (rq && m_armed[i]) begin
         m_run[i]   = 1'b0;
         m_left[i]  = p_h(i);
         m_soft[i]  = 1'b1;
         m_armed[i] = 1'b0;
         m_cnt[i]   = 0;
      end else begin
         if (!rq) m_armed[i] = 1'b1;
         if (m_cnt[i] < p_max(i)) m_cnt[i] = m_cnt[i] + 1;
      end
   endtask

   function automatic exp_t model_out(input int i);
      exp_t r;
      r.rst_n = m_run[i];
      r.done  = m_done[i];
      r.ack   = m_ack[i];
`ifdef CLKNRST_CYCLE_CNT_EN
      r.cnt   = m_cnt[i];
`else
      r.cnt   = 0;
`endif
      return r;
   endfunction

   task automatic check(input string name, input longint unsigned act, input longint unsigned req_v);
      n_chk++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req_v);
      end
   endtask

   // Monitor: after every rising edge, compare each instance against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (q_a.size() > 0) begin
         e_a = q_a.pop_front();
         check("a_rst_n", 64'(rstn_a), 64'(e_a.rst_n));
         check("a_rst",   64'(rst_a),  64'(!e_a.rst_n));
         check("a_done",  64'(done_a), 64'(e_a.done));
         check("a_ack",   64'(ack_a),  64'(e_a.ack));
         check("a_cnt",   64'(cnt_a),  e_a.cnt);
      end
      if (q_b.size() > 0) begin
         e_b = q_b.pop_front();
         check("b_rst_n", 64'(rstn_b), 64'(e_b.rst_n));
         check("b_rst",   64'(rst_b),  64'(!e_b.rst_n));
         check("b_done",  64'(done_b), 64'(e_b.done));
         check("b_ack",   64'(ack_b),  64'(e_b.ack));
         check("b_cnt",   64'(cnt_b),  e_b.cnt);
      end
   end

   task automatic check_async();
      check("async_a_rst_n", 64'(rstn_a), 64'd0);
      check("async_a_rst",   64'(rst_a),  64'd1);
      check("async_a_done",  64'(done_a), 64'd0);
      check("async_a_ack",   64'(ack_a),  64'd0);
      check("async_a_cnt",   64'(cnt_a),  64'd0);
      check("async_b_rst_n", 64'(rstn_b), 64'd0);
      check("async_b_rst",   64'(rst_b),  64'd1);
      check("async_b_cnt",   64'(cnt_b),  64'd0);
   endtask

   // One cycle of stimulus: drive at the falling edge, predict the state after the next rising edge.
   task automatic step(input bit rn, input bit rq);
      @(negedge clk);
      req = rq;
      if (!rn && reset_n) begin
         reset_n = 1'b0;
         model_reset(0);
         model_reset(1);
         #1;
         check_async();
      end
      reset_n = rn;
      model_edge(0, rn, rq);
      model_edge(1, rn, rq);
      q_a.push_back(model_out(0));
      q_b.push_back(model_out(1));
   endtask

   // Directed scenarios followed by randomized reset/request traffic.
   initial begin
      bit rq;
      model_reset(0);
      model_reset(1);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0);

      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 34; i++) step(1'b1, 1'b0);

      for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

      step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0);

      rq = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 20) rq = ~rq;
         if ($urandom_range(0, 99) < 2) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b0, rq);
         end else begin
            step(1'b1, rq);
         end
      end

      for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

      @(negedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
